fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the team's RISC-V core. It sits upstream of the decode/register-read stage. It drives the PC to a synchronous instruction memory and captures the returned word with the PC that fetched it. Fetched pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake. A one-cycle redirect input (branch/jump) flushes in-flight and buffered fetches and restarts at a new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  32  fetch address; meaningful when `imem_req`=1.
- `imem_insn`  in  32  instruction word; valid the cycle after the matching `imem_req`.
- `redirect_valid`  in  1  one-cycle pulse: flush and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC.
- `id_valid`  out  1  head entry available to decode.
- `id_ready`  in  1  decode accepts head entry.
- `id_insn`  out  32  head instruction.
- `id_pc`  out  32  PC of head instruction.
- `fetch_fault`  out  1  misaligned redirect trap. Present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- **States**
  - IDLE: reset state; left on the first clock after `rst_n` deasserts.
  - RUN: normal fetching.
  - FAULT: entered only with the macro; left only by reset.
- **Fetch PC register `fpc`**
  - Reset value is `RESET_PC`; `imem_addr` = `fpc` combinationally.
  - On a request cycle without redirect, `fpc` advances by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- **Request gating (credit-based)**
  - `imem_req` = (state==RUN) & !redirect_valid & (occ + inflight − (id_valid & id_ready) < DEPTH).
  - `inflight` is 1 if a request was issued last cycle and not killed.
- **Response capture**
  - In the cycle after a live request, {`imem_insn`, issued PC} is written at the FIFO tail.
  - The issued PC is held in a register; it is not recomputed.
- **Dequeue**
  - `id_valid` = occ≠0.
  - `id_insn`/`id_pc` are the FIFO head, driven from storage.
  - Head pops when `id_valid & id_ready`.
- **Simultaneous events**
  - Enqueue and dequeue in the same cycle keep occ unchanged. This is legal at occ==DEPTH only if a dequeue occurs; the credit rule guarantees this.
- **Redirect in cycle r**
  - A handshake in cycle r completes normally.
  - At the end of cycle r, the FIFO is flushed (occ←0), the in-flight response is killed (its data is discarded in cycle r+1), and `fpc`←`redirect_pc`.
  - No request is issued in cycle r.
- **Redirect in the cycle a killed response returns**
  - The newer redirect wins; the response is still discarded.
- **Reset mid-operation**
  - All state returns to reset values immediately (asynchronous).
  - Any response in flight is dropped.
- Decode must not depend on `id_insn`/`id_pc` while `id_valid`=0.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_insn`=0, `id_pc`=0, `fetch_fault`=0.
- **Start-up**
  - The first rising edge after deassert moves IDLE→RUN.
  - The first request is in the next cycle (cycle 1).
- **Latency**
  - Request in cycle k → data captured at the end of k+1 → `id_valid` in cycle k+2.
  - Redirect in cycle r → request to `redirect_pc` in r+1 → `id_valid` with that PC in r+3.
- **Throughput:** one instruction per cycle with `id_ready` held high and DEPTH≥2.
- **Back-pressure**
  - With `id_ready`=0, requests stop once occ+inflight reaches DEPTH.
  - No response is ever dropped for lack of space.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- **Defined**
  - A redirect with `redirect_pc[1:0]`≠0 flushes as usual, then enters FAULT.
  - In FAULT: `fetch_fault`=1, and `imem_req`=0 and `id_valid`=0 until reset.
- **Undefined**
  - The `fetch_fault` port is absent.
  - `redirect_pc[1:0]` is forced to 2'b00 when loaded; FAULT is unreachable.

## Test plan
- **Reset and stream:** `RESET_PC`=0, `id_ready`=1, memory returns addr^32'hA5A5_0000 → `id_pc` 0,4,8,C on consecutive cycles starting cycle 3, with `id_insn` matching.
- **Back-pressure:** `id_ready`=0 for 10 cycles → `imem_req` stops after DEPTH requests. Release → entries 0,4 delivered in order, then 8; no gaps or duplicates.
- **Redirect mid-stream:** redirect to 32'h100 while PC 8 is in flight and PC 4 is buffered → PCs 4 and 8 are never presented; next `id_pc`=32'h100, three cycles after the redirect.
- **Redirect with handshake:** `id_ready`=1 and `redirect_valid`=1 in the same cycle with head PC 0 → PC 0 is consumed exactly once, then the stream resumes at the redirect target.
- **Wrap:** redirect to 32'hFFFF_FFF8 → `id_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Misaligned redirect:** redirect to 32'h102.
  - With the macro: `fetch_fault`=1 next cycle, `imem_req`/`id_valid` stay 0 until `rst_n` pulses.
  - Without the macro: the stream resumes at 32'h100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//
// Drives the fetch PC to a synchronous instruction memory, captures the returned
// word with the PC that fetched it into a small FIFO, and hands {insn, pc} pairs
// to decode over a valid/ready handshake. A one-cycle redirect flushes buffered
// and in-flight fetches and restarts fetching at the redirect PC.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a PC with [1:0] != 0 flushes, then traps into a
//               FAULT state (fetch_fault=1, no requests, no valid) until reset.
//   undefined : fetch_fault port absent; redirect_pc[1:0] is forced to 2'b00.
//
// Parameters:
//   RESET_PC       first fetch address after reset
//   DEPTH          FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   imem_req       fetch request this cycle
//   imem_addr      fetch address (= fetch PC register)
//   imem_insn      instruction word, valid the cycle after a request
//   redirect_valid one-cycle flush/restart pulse
//   redirect_pc    restart PC
//   id_valid       head entry available to decode
//   id_ready       decode accepts the head entry
//   id_insn        head instruction
//   id_pc          PC of head instruction
//   fetch_fault    misaligned redirect trap (only with FETCH_ALIGN_CHECK_EN)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_insn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_insn,
  output logic [31:0] id_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   issued_pc_q;
  logic          inflight_q;
  logic [31:0]   fifo_insn_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   occ_q, occ_d;

  logic          deq, enq;
  logic          misaligned;
  logic [31:0]   redirect_target;
  int unsigned   credit_used;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault     = (state_q == StFault);
`else
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign misaligned      = 1'b0;
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign imem_addr = fpc_q;
  assign id_valid  = (occ_q != '0) && (state_q != StFault);
  assign id_insn   = fifo_insn_q[rd_ptr_q];
  assign id_pc     = fifo_pc_q[rd_ptr_q];

  // Credit check: buffered + in-flight entries, less the one leaving this
  // cycle, must leave room for the response to a new request.
  always_comb begin
    deq         = id_valid & id_ready;
    enq         = inflight_q;
    credit_used = 32'(occ_q) + 32'(inflight_q) - 32'(deq);
    imem_req    = (state_q == StRun) && !redirect_valid && (credit_used < DEPTH);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StRun;
      StRun:   state_d = StRun;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    if (redirect_valid && misaligned) begin
      state_d = StFault;
    end
  end

  always_comb begin
    fpc_d = fpc_q;
    if (redirect_valid) begin
      fpc_d = redirect_target;
    end else if (imem_req) begin
      fpc_d = fpc_q + 32'd4;
    end
  end

  // A redirect empties the FIFO regardless of any same-cycle enqueue.
  always_comb begin
    occ_d = occ_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    if (redirect_valid) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      fpc_q       <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      // imem_req is already low on a redirect, which kills the next response.
      inflight_q <= imem_req;
      if (imem_req) begin
        issued_pc_q <= fpc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_insn_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (enq) begin
        fifo_insn_q[wr_ptr_q] <= imem_insn;
        fifo_pc_q[wr_ptr_q]   <= issued_pc_q;
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (enq) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (deq) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A queue-based reference model is checked against the DUT every cycle, and
// directed scenarios pin the model with hand-computed literal expectations.
// Instruction memory returns addr ^ 32'hA5A5_0000 one cycle after a request.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_insn = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_insn;
  logic [31:0] id_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_insn      (imem_insn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_insn        (id_insn),
    .id_pc          (id_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  // Synchronous instruction memory.
  always @(posedge clk) begin
    imem_insn <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] acc_q[$];

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  logic get_fault;
  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    get_fault = fetch_fault;
`else
    get_fault = 1'b0;
`endif
  end

  // Reference model: m_st 0=idle 1=run 2=fault; m_q holds buffered PCs.
  int          m_st;
  logic [31:0] m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fpc;

  always @(negedge clk) begin
    bit e_valid;
    bit e_req;
    bit m_hs;
    int credit;
    if (!rst_n) begin
      m_st   = 0;
      m_q.delete();
      m_pend = 1'b0;
      m_fpc  = RESET_PC;
    end else begin
      e_valid = (m_q.size() != 0) && (m_st != 2);
      m_hs    = e_valid && (id_ready === 1'b1);
      credit  = m_q.size() + (m_pend ? 1 : 0) - (m_hs ? 1 : 0);
      e_req   = (m_st == 1) && (redirect_valid !== 1'b1) && (credit < int'(DEPTH));

      chk1("model_req", imem_req, e_req);
      chk32("model_addr", imem_addr, m_fpc);
      chk1("model_valid", id_valid, e_valid);
      if (e_valid) begin
        chk32("model_pc", id_pc, m_q[0]);
        chk32("model_insn", id_insn, m_q[0] ^ KEY);
      end
      if (ALIGN_CHECK) chk1("model_fault", get_fault, m_st == 2);

      if (id_valid && id_ready) acc_q.push_back(id_pc);

      if (m_hs) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_pc);
      m_pend = 1'b0;
      if (m_st == 0) m_st = 1;
      if (redirect_valid) begin
        m_q.delete();
        m_fpc = ALIGN_CHECK ? redirect_pc : (redirect_pc & ~32'h3);
        if (ALIGN_CHECK && redirect_pc[1:0] != 2'b00) m_st = 2;
      end else if (e_req) begin
        m_pend    = 1'b1;
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end
    end
  end

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  // Leaves the caller mid-way through cycle 0 (IDLE) of a fresh run.
  task automatic restart(input logic rdy);
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    id_ready       = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int nreq;
    int n300;
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, RESET_PC);
    chk1("rst_valid", id_valid, 1'b0);
    chk32("rst_insn", id_insn, 32'h0);
    chk32("rst_pc", id_pc, 32'h0);
    chk1("rst_fault", get_fault, 1'b0);

    // Reset and stream.
    restart(1'b1);
    chk1("c0_idle_req", imem_req, 1'b0);
    cyc(1, 0, 0);
    chk1("c1_req", imem_req, 1'b1);
    chk32("c1_addr", imem_addr, 32'h0);
    cyc(1, 0, 0);
    chk1("c2_valid", id_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      chk1("stream_valid", id_valid, 1'b1);
      chk32("stream_pc", id_pc, 32'(4 * i));
      chk32("stream_insn", id_insn, 32'(4 * i) ^ KEY);
    end

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("async_valid", id_valid, 1'b0);
    chk1("async_req", imem_req, 1'b0);
    chk32("async_addr", imem_addr, RESET_PC);
    chk32("async_pc", id_pc, 32'h0);

    // Back-pressure.
    restart(1'b0);
    nreq = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 0);
      if (imem_req) nreq++;
    end
    chk32("bp_req_count", 32'(nreq), 32'(DEPTH));
    chk32("bp_hold_pc", id_pc, 32'h0);
    cyc(1, 0, 0);
    chk32("bp_pc0", id_pc, 32'h0);
    cyc(1, 0, 0);
    chk32("bp_pc4", id_pc, 32'h4);
    cyc(1, 0, 0);
    chk32("bp_pc8", id_pc, 32'h8);
    #1;
    chk32("bp_acc_n", 32'(acc_q.size()), 32'd3);
    chk32("bp_acc1", acc_at(1), 32'h4);
    chk32("bp_acc2", acc_at(2), 32'h8);

    // Redirect with PC 4 buffered and PC 8 in flight.
    restart(1'b0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk32("rd_addr8", imem_addr, 32'h8);
    cyc(0, 1, 32'h100);
    chk32("rd_head4", id_pc, 32'h4);
    chk1("rd_noreq", imem_req, 1'b0);
    cyc(1, 0, 0);
    chk1("rd_r1_valid", id_valid, 1'b0);
    chk32("rd_r1_addr", imem_addr, 32'h100);
    cyc(1, 0, 0);
    chk1("rd_r2_valid", id_valid, 1'b0);
    cyc(1, 0, 0);
    chk32("rd_r3_pc", id_pc, 32'h100);
    cyc(1, 0, 0);
    chk32("rd_r4_pc", id_pc, 32'h104);
    #1;
    chk32("rd_acc_n", 32'(acc_q.size()), 32'd3);
    chk32("rd_acc0", acc_at(0), 32'h0);
    chk32("rd_acc1", acc_at(1), 32'h100);

    // Redirect in the same cycle as a handshake of PC 0.
    restart(1'b1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 32'h200);
    chk32("hs_head0", id_pc, 32'h0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk32("hs_pc200", id_pc, 32'h200);
    cyc(1, 0, 0);
    #1;
    chk32("hs_acc_n", 32'(acc_q.size()), 32'd3);
    chk32("hs_acc0", acc_at(0), 32'h0);
    chk32("hs_acc1", acc_at(1), 32'h200);

    // Address wrap.
    cyc(1, 1, 32'hFFFF_FFF8);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk32("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0);
    chk32("wrap_pc0", id_pc, 32'hFFFF_FFF8);
    cyc(1, 0, 0);
    chk32("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0);
    chk32("wrap_pc2", id_pc, 32'h0);
    chk32("wrap_insn2", id_insn, KEY);

    // Back-to-back redirects: the newer one wins.
    cyc(1, 1, 32'h300);
    cyc(1, 1, 32'h400);
    cyc(1, 0, 0);
    chk32("dbl_addr", imem_addr, 32'h400);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk32("dbl_pc", id_pc, 32'h400);
    #1;
    n300 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 32'h300) n300++;
    chk32("dbl_no300", 32'(n300), 32'd0);

    // Misaligned redirect.
    cyc(1, 1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    cyc(1, 0, 0);
    chk1("mis_fault", get_fault, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      chk1("mis_req", imem_req, 1'b0);
      chk1("mis_valid", id_valid, 1'b0);
    end
    restart(1'b1);
    chk1("mis_fault_clr", get_fault, 1'b0);
    cyc(1, 0, 0);
    chk1("mis_req_after_rst", imem_req, 1'b1);
`else
    cyc(1, 0, 0);
    chk32("mis_addr", imem_addr, 32'h100);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk32("mis_pc", id_pc, 32'h100);
    chk32("mis_insn", id_insn, 32'h100 ^ KEY);
`endif

    cyc(1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
